// File: rtl/fifo_param_if.sv
// Handshake/data bundle between a FIFO user (master) and fifo_param (slave).
// Parameters must match the fifo_param instance they connect to.
interface fifo_param_if #(
   parameter int DATA_BITS = 10,
   parameter int ADDR_BITS = 3
);
   logic [DATA_BITS-1:0] fifo_data_in;
   logic                 fifo_write;
   logic                 fifo_read;
   logic [ADDR_BITS:0]   high_limit;
   logic [ADDR_BITS:0]   low_limit;
   logic                 error_clear;
   logic [DATA_BITS-1:0] fifo_data_out;
   logic                 fifo_valid_out;
   logic                 fifo_full_out;
   logic                 fifo_empty_out;
   logic                 almost_full_out;
   logic                 almost_empty_out;
   logic [ADDR_BITS:0]   fifo_count_out;
   logic                 error_write_out;
   logic                 error_read_out;
   logic                 error_fifo_out;

   modport master (
      output fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, error_clear,
      input  fifo_data_out, fifo_valid_out, fifo_full_out, fifo_empty_out,
             almost_full_out, almost_empty_out, fifo_count_out,
             error_write_out, error_read_out, error_fifo_out
   );

   modport slave (
      input  fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, error_clear,
      output fifo_data_out, fifo_valid_out, fifo_full_out, fifo_empty_out,
             almost_full_out, almost_empty_out, fifo_count_out,
             error_write_out, error_read_out, error_fifo_out
   );
endinterface

// File: rtl/fifo_param.sv
// Synchronous FIFO, DEPTH = 2**ADDR_BITS, count-decoded flags and sticky over/underflow errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module fifo_param #(
   parameter int DATA_BITS = 10,
   parameter int ADDR_BITS = 3
) (
   input  logic clk,
   input  logic reset,
   fifo_param_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic                 err_wr_q, err_wr_d;
   logic                 err_rd_q, err_rd_d;
   logic                 full, empty;
   logic                 wr_acc, rd_acc;

   assign full   = (count_q == DEPTH_C);
   assign empty  = (count_q == '0);
   assign wr_acc = bus.fifo_write & ~full;
   assign rd_acc = bus.fifo_read & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_wr_d = err_wr_q;
      err_rd_d = err_rd_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A fresh rejection wins over a same-cycle clear so no error event is lost.
      if (bus.fifo_write & full)      err_wr_d = 1'b1;
      else if (bus.error_clear)       err_wr_d = 1'b0;
      if (bus.fifo_read & empty)      err_rd_d = 1'b1;
      else if (bus.error_clear)       err_rd_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_wr_q <= 1'b0;
         err_rd_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_wr_q <= err_wr_d;
         err_rd_q <= err_rd_d;
      end
   end

   // Storage is deliberately not reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= bus.fifo_data_in;
   end

`ifdef FIFO_FWFT_EN
   assign bus.fifo_data_out  = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.fifo_valid_out = ~empty;
`else
   logic [DATA_BITS-1:0] dout_q;
   logic                 vld_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= rd_acc;
         if (rd_acc) dout_q <= mem_q[rd_ptr_q];
      end
   end

   assign bus.fifo_data_out  = dout_q;
   assign bus.fifo_valid_out = vld_q;
`endif

   assign bus.fifo_full_out    = full;
   assign bus.fifo_empty_out   = empty;
   assign bus.almost_full_out  = (bus.high_limit != '0) && (count_q >= bus.high_limit);
   assign bus.almost_empty_out = (count_q <= bus.low_limit);
   assign bus.fifo_count_out   = count_q;
   assign bus.error_write_out  = err_wr_q;
   assign bus.error_read_out   = err_rd_q;
   assign bus.error_fifo_out   = err_wr_q | err_rd_q;
endmodule
